// File: rtl/uart_rx_axis_ctrl.sv
// UART receive byte framer: takes bytes from the UART receiver, handles
// parity-failed bytes, closes packets on idle timeout or maximum length,
// buffers them in a small FIFO and presents them as an AXI-Stream master.
// Sticky overflow and saturating error counters are kept for software.
module uart_rx_axis_ctrl #(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int MAX_PKT     = 64,
    parameter int IDLE_CYCLES = 10000,
    parameter int CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          rx_data,
    input  logic                          rx_valid,
    input  logic                          parity_error,
    input  logic                          drop_on_err,
    input  logic                          clr_status,
    output logic [DATA_BITS-1:0]          m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    output logic                          overflow,
    output logic [CNT_W-1:0]              err_count,
    output logic [CNT_W-1:0]              ovf_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int TMR_W  = $clog2(IDLE_CYCLES);
    localparam int PCNT_W = $clog2(MAX_PKT + 1);
    localparam int ENT_W  = DATA_BITS + 2;

    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(IDLE_CYCLES - 1);
    localparam logic [PCNT_W-1:0] PKT_LAST = PCNT_W'(MAX_PKT - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state, state_next;

    // Hold register: one byte is kept back so tlast can be decided once the
    // next byte (or the idle timeout) shows whether the packet continues.
    logic [DATA_BITS-1:0] pend_data;
    logic                 pend_user;

    logic [TMR_W-1:0]  timer;
    logic [PCNT_W-1:0] pkt_cnt;

    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_next;
    logic             tvalid_r;

    logic accept;
    logic new_user;
    logic fifo_full;
    logic at_max;
    logic pop;

    logic push;
    logic push_last;
    logic load_pend;
    logic drop;
    logic timer_clr;
    logic timer_inc;
    logic pkt_clr;
    logic pkt_inc;

    logic [CNT_W-1:0] err_base;
    logic [CNT_W-1:0] ovf_base;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A parity-failed byte is only forwarded when the host wants it tagged.
    assign accept    = rx_valid | (parity_error & ~drop_on_err);
    assign new_user  = parity_error;
    // Push eligibility is judged on the level before any same-cycle pop.
    assign fifo_full = (fifo_level == LVL_FULL);
    assign at_max    = (pkt_cnt == PKT_LAST);
    assign pop       = tvalid_r & m_axis_tready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        push_last  = 1'b0;
        load_pend  = 1'b0;
        drop       = 1'b0;
        timer_clr  = 1'b0;
        timer_inc  = 1'b0;
        pkt_clr    = 1'b0;
        pkt_inc    = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_pend  = 1'b1;
                    timer_clr  = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    // Arrival beats a coincident timeout and restarts the timer.
                    timer_clr = 1'b1;
                    if (fifo_full) begin
                        drop = 1'b1;
                    end else begin
                        push      = 1'b1;
                        push_last = at_max;
                        load_pend = 1'b1;
                        pkt_clr   = at_max;
                        pkt_inc   = ~at_max;
                    end
                end else if (timer == TMR_LAST) begin
                    state_next = FLUSH;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            FLUSH: begin
                if (fifo_full) begin
                    drop      = accept;
                    timer_clr = accept;
                end else begin
                    push      = 1'b1;
                    push_last = 1'b1;
                    pkt_clr   = 1'b1;
                    // A byte arriving as the held one closes starts a new packet.
                    if (accept) begin
                        load_pend  = 1'b1;
                        timer_clr  = 1'b1;
                        state_next = HOLD;
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Hold register load; data only, no reset needed.
    always_ff @(posedge clk) begin
        if (load_pend) begin
            pend_data <= rx_data;
            pend_user <= new_user;
        end
    end

    // Idle timer and packet byte counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer   <= '0;
            pkt_cnt <= '0;
        end else begin
            if (timer_clr) begin
                timer <= '0;
            end else if (timer_inc) begin
                timer <= timer + TMR_W'(1);
            end
            if (pkt_clr) begin
                pkt_cnt <= '0;
            end else if (pkt_inc) begin
                pkt_cnt <= pkt_cnt + PCNT_W'(1);
            end
        end
    end

    // FIFO storage write; entry layout is {user, last, data}.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {pend_user, push_last, pend_data};
        end
    end

    // Occupancy after this cycle's push and pop.
    always_comb begin
        level_next = fifo_level;
        case ({push, pop})
            2'b10:   level_next = fifo_level + LVL_W'(1);
            2'b01:   level_next = fifo_level - LVL_W'(1);
            default: level_next = fifo_level;
        endcase
    end

    // FIFO pointers, level and registered stream valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            tvalid_r   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_level <= level_next;
            tvalid_r   <= (level_next != '0);
        end
    end

    // Clear takes effect first so a coincident event still counts once.
    always_comb begin
        err_base = clr_status ? '0 : err_count;
        ovf_base = clr_status ? '0 : ovf_count;
    end

    // Sticky overflow flag and saturating status counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            err_count <= '0;
            ovf_count <= '0;
        end else begin
            overflow  <= (overflow & ~clr_status) | drop;
            err_count <= parity_error ? sat_inc(err_base) : err_base;
            ovf_count <= drop ? sat_inc(ovf_base) : ovf_base;
        end
    end

    // Head entry drives the stream; gated so outputs read zero when empty.
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tdata  = tvalid_r ? mem[rd_ptr][DATA_BITS-1:0] : '0;
    assign m_axis_tlast  = tvalid_r & mem[rd_ptr][DATA_BITS];
    assign m_axis_tuser  = tvalid_r & mem[rd_ptr][DATA_BITS+1];

endmodule

// File: doc/uart_rx_axis_ctrl.md
Name: uart_rx_axis_ctrl

Overview:
Sits between the UART receiver and the downstream AXI-Stream fabric. Consumes received bytes, filters or tags parity-failed bytes, frames them into packets, buffers them in a small FIFO and presents them as an AXI-Stream master. Packets close on a line-idle timeout or a maximum length. Keeps sticky status and saturating error counters for software.

Parameters:
DATA_BITS, 8, byte width; must match the receiver.
FIFO_DEPTH, 16, FIFO entries; power of 2, >=2.
MAX_PKT, 64, maximum bytes per packet; >=1.
IDLE_CYCLES, 10000, clocks with no rx_valid before the held byte is closed with tlast; >=2.
CNT_W, 16, width of the status counters.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
rx_data  in  DATA_BITS  received byte from the receiver
rx_valid  in  1  1-clk strobe, byte good
parity_error  in  1  1-clk strobe, byte failed parity; rx_data is valid in the same cycle
drop_on_err  in  1  1 = discard parity-failed bytes; 0 = pass them with tuser=1
clr_status  in  1  1-clk pulse; clears overflow, err_count and ovf_count
m_axis_tdata  out  DATA_BITS  stream data
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tlast  out  1  last byte of packet
m_axis_tuser  out  1  byte had a parity error
overflow  out  1  sticky: a byte was lost because the FIFO was full
err_count  out  CNT_W  saturating count of parity_error strobes
ovf_count  out  CNT_W  saturating count of dropped bytes
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=0, async): all outputs 0, FIFO empty, state EMPTY, pkt_cnt=0, idle timer=0.
- Accepted byte: rx_valid=1, or parity_error=1 with drop_on_err=0. A parity_error with drop_on_err=1 is discarded. It only increments err_count and does not restart the idle timer.
- err_count increments on every parity_error regardless of drop_on_err.
- One-byte hold register (pend_data, pend_user). It lets tlast be decided after the fact.
- FSM states:
  - EMPTY: no byte held. On an accepted byte, load pend and go to HOLD with timer=0.
  - HOLD: timer increments each clk.
    - Accepted byte arrives: push pend with last=(pkt_cnt+1==MAX_PKT), then load the new byte into pend and set timer=0. Update pkt_cnt: 0 if last, else +1.
    - timer reaches IDLE_CYCLES-1 with no byte: go to FLUSH.
  - FLUSH: push pend with last=1, set pkt_cnt=0, go to EMPTY. Stays in FLUSH while FIFO is full.
- Push rule: push only when fifo_level<FIFO_DEPTH, evaluated before any same-cycle pop (a pop does not free space for a push in the same cycle).
- HOLD with FIFO full and an accepted byte arrives: the new byte is dropped, pend is unchanged, overflow<=1, ovf_count+1, timer=0.
- FLUSH with FIFO full and an accepted byte arrives: the new byte is dropped, same accounting as above.
- Byte arrival and timeout in the same cycle: arrival wins, timer restarts.
- MAX_PKT=1: every push has last=1.
- FIFO entry = {user, last, data}. Outputs are driven from the head entry. m_axis_tvalid = (fifo_level!=0), registered. A pushed byte is visible 1 clk after its push cycle.
- AXIS rule: pop on tvalid&&tready. tdata, tlast and tuser stay stable while tvalid&&!tready. tvalid never drops without a handshake.
- Same-cycle push and pop when not full: level unchanged. Pointers wrap modulo FIFO_DEPTH.
- Counters saturate at all-ones.
- clr_status in the same cycle as an event: clear is applied first, then the event. Result is count=1 or overflow=1.
- Reset mid-packet: the held byte and FIFO contents are lost. No partial-packet tlast is emitted.

Test Plan:
Use IDLE_CYCLES=20, FIFO_DEPTH=4, MAX_PKT=3, tready=1 unless stated.
- Single byte 0xA5, then silence -> no output for 19 clks; then 0xA5 with tlast=1, tuser=0.
- Bytes 0x01..0x05 each 5 clks apart, then silence -> 01,02,03 (tlast on 03), then 04,05 (tlast on 05 after timeout).
- parity_error with 0x3C, drop_on_err=1 -> no output, err_count=1. Same stimulus with drop_on_err=0 -> 0x3C output with tuser=1, err_count=2.
- tready=0, send 6 bytes -> 4 bytes in FIFO, 1 held, 1 dropped: overflow=1, ovf_count=1. Then raise tready -> 5 bytes in order, last with tlast=1; tdata held stable while stalled.
- clr_status pulse in the same cycle as a parity_error -> err_count=1. clr_status alone -> overflow=0, both counters 0.
- Assert rst low mid-packet -> all outputs 0 immediately. After release, a new byte 0x77 produces a clean 1-byte packet with tlast=1.
